// File: rtl/core_pkg.sv
// core_pkg: shared widths and fetch/queue record types for the front end
package core_pkg;
    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    typedef struct packed {
        logic [INSTR_W-1:0] instr1;
        logic [INSTR_W-1:0] instr2;
        logic [PC_W-1:0]    pc;
    } fetch_pair_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;
endpackage

// File: rtl/fetch_decode_queue_if.sv
// fetch_decode_queue_if: fetch-side pair input, flush, decode-side pop and queue outputs
interface fetch_decode_queue_if
    import core_pkg::*;
#(
    parameter int DEPTH = 8
);
    logic                       in_valid;
    logic [INSTR_W-1:0]         instr1;
    logic [INSTR_W-1:0]         instr2;
    logic [PC_W-1:0]            pc_in;
    logic                       is_branch_taken;
    logic [1:0]                 pop;
    logic                       stall;
    logic                       out_valid1;
    logic                       out_valid2;
    logic [INSTR_W-1:0]         out_instr1;
    logic [INSTR_W-1:0]         out_instr2;
    logic [PC_W-1:0]            out_pc1;
    logic [PC_W-1:0]            out_pc2;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;

    modport master (
        output in_valid, instr1, instr2, pc_in, is_branch_taken, pop,
        input  stall, out_valid1, out_valid2, out_instr1, out_instr2, out_pc1, out_pc2, count, overflow
    );

    modport slave (
        input  in_valid, instr1, instr2, pc_in, is_branch_taken, pop,
        output stall, out_valid1, out_valid2, out_instr1, out_instr2, out_pc1, out_pc2, count, overflow
    );
endinterface

// File: rtl/instr_ring_ram.sv
// instr_ring_ram: ring storage writing and reading two consecutive entries per cycle
module instr_ring_ram
    import core_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  entry_t        wd0,
    input  entry_t        wd1,
    input  logic [AW-1:0] ra,
    output entry_t        rd0,
    output entry_t        rd1
);
    entry_t mem [DEPTH];

    // pair write: older entry at wa, younger at the next slot (wraps with the pointer width)
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa]        <= wd0;
            mem[wa + 1'b1] <= wd1;
        end
    end

    assign rd0 = mem[ra];
    assign rd1 = mem[ra + 1'b1];
endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: dual-wide FWFT instruction queue between fetch and decode
module fetch_decode_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic                 clk,
    input logic                 reset,
    fetch_decode_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, free;
    logic          overflow, push, drop, flush, v1, v2;
    logic [1:0]    pop_eff, n;
    fetch_pair_t   pair;
    entry_t        wd0, wd1, rd0, rd1;

    assign flush   = bus.is_branch_taken;
    assign free    = CW'(DEPTH) - count;
    assign push    = bus.in_valid && free >= CW'(2);
    assign drop    = bus.in_valid && free < CW'(2);
    assign pop_eff = (bus.pop == 2'd3) ? 2'd2 : bus.pop;
    assign n       = (count < CW'(pop_eff)) ? count[1:0] : pop_eff;
    assign pair    = '{instr1: bus.instr1, instr2: bus.instr2, pc: bus.pc_in};
    assign wd0     = '{instr: pair.instr1, pc: pair.pc};
    assign wd1     = '{instr: pair.instr2, pc: pair.pc + 1'b1};

    instr_ring_ram #(.DEPTH(DEPTH)) u_ram (
        .clk (clk),
        .we  (push && !flush),
        .wa  (wr_ptr),
        .wd0 (wd0),
        .wd1 (wd1),
        .ra  (rd_ptr),
        .rd0 (rd0),
        .rd1 (rd1)
    );

    // pointers and occupancy; a taken branch empties the queue but leaves the sticky overflow alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr   <= wr_ptr + AW'({push, 1'b0});
            rd_ptr   <= rd_ptr + AW'(n);
            count    <= count + CW'({push, 1'b0}) - CW'(n);
            overflow <= overflow | drop;
        end
    end

    assign v1             = count >= CW'(1);
    assign v2             = count >= CW'(2);
    assign bus.stall      = free < CW'(4);
    assign bus.out_valid1 = v1;
    assign bus.out_valid2 = v2;
    assign bus.out_instr1 = v1 ? rd0.instr : '0;
    assign bus.out_pc1    = v1 ? rd0.pc : '0;
    assign bus.out_instr2 = v2 ? rd1.instr : '0;
    assign bus.out_pc2    = v2 ? rd1.pc : '0;
    assign bus.count      = count;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: queue-model scoreboard plus directed literal checks
module tb_fetch_decode_queue;
    logic clk, rst;
    int   tests, fails;

    fetch_decode_queue_if bus ();

    fetch_decode_queue dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: a plain FIFO of instructions and PCs
    logic [15:0] mi[$];
    logic [15:0] mp[$];
    bit          movf;

    initial begin : model
        int pe, n;
        bit acc;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mi.delete();
                mp.delete();
                movf = 1'b0;
            end else if (bus.is_branch_taken) begin
                mi.delete();
                mp.delete();
            end else begin
                pe  = (bus.pop == 2'd3) ? 2 : int'(bus.pop);
                n   = (pe < mi.size()) ? pe : mi.size();
                acc = bus.in_valid && (8 - mi.size()) >= 2;
                if (bus.in_valid && !acc) movf = 1'b1;
                repeat (n) begin
                    void'(mi.pop_front());
                    void'(mp.pop_front());
                end
                if (acc) begin
                    mi.push_back(bus.instr1);
                    mi.push_back(bus.instr2);
                    mp.push_back(bus.pc_in);
                    mp.push_back(bus.pc_in + 16'd1);
                end
            end
            #1;
            chk("m_count", 32'(bus.count), 32'(mi.size()));
            chk("m_stall", 32'(bus.stall), 32'((8 - mi.size()) < 4));
            chk("m_overflow", 32'(bus.overflow), 32'(movf));
            chk("m_valid1", 32'(bus.out_valid1), 32'(mi.size() >= 1));
            chk("m_valid2", 32'(bus.out_valid2), 32'(mi.size() >= 2));
            chk("m_instr1", 32'(bus.out_instr1), (mi.size() >= 1) ? 32'(mi[0]) : 32'd0);
            chk("m_pc1", 32'(bus.out_pc1), (mi.size() >= 1) ? 32'(mp[0]) : 32'd0);
            chk("m_instr2", 32'(bus.out_instr2), (mi.size() >= 2) ? 32'(mi[1]) : 32'd0);
            chk("m_pc2", 32'(bus.out_pc2), (mi.size() >= 2) ? 32'(mp[1]) : 32'd0);
        end
    end

    task automatic drive(input logic v, input logic [15:0] i1, input logic [15:0] i2,
                         input logic [15:0] pc, input logic br, input logic [1:0] p);
        @(negedge clk);
        bus.in_valid        = v;
        bus.instr1          = i1;
        bus.instr2          = i2;
        bus.pc_in           = pc;
        bus.is_branch_taken = br;
        bus.pop             = p;
        @(posedge clk);
        #2;
    endtask

    initial begin : stim
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.instr1 = '0;
        bus.instr2 = '0;
        bus.pc_in = '0;
        bus.is_branch_taken = 1'b0;
        bus.pop = '0;
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_valid1", 32'(bus.out_valid1), 0);
        chk("rst_instr1", 32'(bus.out_instr1), 0);
        rst = 1'b0;

        drive(1, 16'h1111, 16'h2222, 16'h0010, 0, 0);
        chk("t1_valid1", 32'(bus.out_valid1), 1);
        chk("t1_valid2", 32'(bus.out_valid2), 1);
        chk("t1_instr1", 32'(bus.out_instr1), 32'h1111);
        chk("t1_pc1", 32'(bus.out_pc1), 32'h0010);
        chk("t1_instr2", 32'(bus.out_instr2), 32'h2222);
        chk("t1_pc2", 32'(bus.out_pc2), 32'h0011);
        chk("t1_count", 32'(bus.count), 2);
        chk("t1_stall", 32'(bus.stall), 0);

        drive(1, 16'h3333, 16'h4444, 16'h0012, 0, 0);
        drive(1, 16'h5555, 16'h6666, 16'h0014, 0, 0);
        chk("t2_count6", 32'(bus.count), 6);
        chk("t2_stall", 32'(bus.stall), 1);
        drive(1, 16'h7777, 16'h8888, 16'h0016, 0, 0);
        chk("t2_count8", 32'(bus.count), 8);
        chk("t2_ovf0", 32'(bus.overflow), 0);
        drive(1, 16'h9999, 16'hAAAA, 16'h0018, 0, 0);
        chk("t2_ovf1", 32'(bus.overflow), 1);
        chk("t2_count_hold", 32'(bus.count), 8);
        drive(1, 16'hBBBB, 16'hCCCC, 16'h001A, 0, 2);
        chk("full_pop_count", 32'(bus.count), 6);
        chk("full_pop_head", 32'(bus.out_instr1), 32'h3333);
        chk("full_pop_ovf", 32'(bus.overflow), 1);
        repeat (3) drive(0, 0, 0, 0, 0, 2);
        chk("drain_count", 32'(bus.count), 0);

        drive(1, 16'h9999, 16'hAAAA, 16'h0200, 0, 0);
        drive(1, 16'hBBBB, 16'hCCCC, 16'h0202, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        chk("t3_head_a", 32'(bus.out_instr1), 32'hAAAA);
        chk("t3_pc_a", 32'(bus.out_pc1), 32'h0201);
        drive(0, 0, 0, 0, 0, 1);
        chk("t3_instr1", 32'(bus.out_instr1), 32'hBBBB);
        chk("t3_pc1", 32'(bus.out_pc1), 32'h0202);
        chk("t3_instr2", 32'(bus.out_instr2), 32'hCCCC);
        chk("t3_pc2", 32'(bus.out_pc2), 32'h0203);
        chk("t3_count2", 32'(bus.count), 2);
        drive(0, 0, 0, 0, 0, 3);
        chk("t3_count0", 32'(bus.count), 0);
        chk("t3_valid1", 32'(bus.out_valid1), 0);
        chk("t3_valid2", 32'(bus.out_valid2), 0);
        chk("t3_instr1_z", 32'(bus.out_instr1), 0);
        chk("t3_pc2_z", 32'(bus.out_pc2), 0);

        drive(1, 16'h0101, 16'h0202, 16'h0300, 0, 0);
        drive(1, 16'h0303, 16'h0404, 16'h0302, 0, 0);
        chk("t4_count4", 32'(bus.count), 4);
        drive(1, 16'h5555, 16'h6666, 16'h0304, 1, 2);
        chk("t4_count0", 32'(bus.count), 0);
        chk("t4_stall", 32'(bus.stall), 0);
        chk("t4_valid1", 32'(bus.out_valid1), 0);
        chk("t4_valid2", 32'(bus.out_valid2), 0);
        drive(1, 16'h7777, 16'h8888, 16'h0400, 0, 0);
        chk("t4_repush", 32'(bus.out_instr1), 32'h7777);
        chk("t4_recount", 32'(bus.count), 2);

        drive(1, 16'hE001, 16'hE002, 16'hFFFF, 0, 2);
        chk("t5_pc1", 32'(bus.out_pc1), 32'hFFFF);
        chk("t5_pc2", 32'(bus.out_pc2), 32'h0000);
        chk("t5_instr1", 32'(bus.out_instr1), 32'hE001);
        for (int k = 0; k < 20; k++) begin
            drive(1, 16'(16'h1000 + 2 * k), 16'(16'h1001 + 2 * k), 16'(16'h2000 + 2 * k), 0, 2);
            chk("t5_loop_count", 32'(bus.count), 2);
            chk("t5_loop_instr1", 32'(bus.out_instr1), 32'h1000 + 32'(2 * k));
            chk("t5_loop_instr2", 32'(bus.out_instr2), 32'h1001 + 32'(2 * k));
        end

        drive(0, 0, 0, 0, 0, 2);
        drive(1, 16'hA001, 16'hA002, 16'h0500, 0, 0);
        drive(1, 16'hA003, 16'hA004, 16'h0502, 0, 0);
        drive(1, 16'hA005, 16'hA006, 16'h0504, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        chk("t6_count5", 32'(bus.count), 5);
        chk("t6_ovf_pre", 32'(bus.overflow), 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_count", 32'(bus.count), 0);
        chk("t6_ovf", 32'(bus.overflow), 0);
        chk("t6_stall", 32'(bus.stall), 0);
        chk("t6_valid1", 32'(bus.out_valid1), 0);
        chk("t6_valid2", 32'(bus.out_valid2), 0);
        chk("t6_instr1", 32'(bus.out_instr1), 0);
        chk("t6_pc1", 32'(bus.out_pc1), 0);
        chk("t6_instr2", 32'(bus.out_instr2), 0);
        chk("t6_pc2", 32'(bus.out_pc2), 0);
        bus.in_valid = 1'b0;
        bus.pop = '0;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 16'hC001, 16'hC002, 16'h0600, 0, 0);
        chk("t6_resume", 32'(bus.out_instr2), 32'hC002);
        drive(0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
